// File: rtl/reset_sequencer.sv
// Releases NUM_DOMAINS active-low resets in index order after a hold period and clock lock.
// Latency: first release HOLD_CYCLES+1 edges after reset; no backpressure (sw reset and lock loss restart the sequence).
module reset_sequencer #(
    parameter int NUM_DOMAINS = 3,
    parameter int HOLD_CYCLES = 16,
    parameter int STAGE_GAP   = 8
) (
    input  logic                   clk,
    input  logic                   i_rstn,
    input  logic                   i_sw_rst,
    input  logic                   i_lock,
    output logic [NUM_DOMAINS-1:0] o_rst_n,
    output logic                   o_done,
    output logic                   o_lock_lost,
    output logic [1:0]             o_state
);

    localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int GW = (STAGE_GAP > 1) ? $clog2(STAGE_GAP) : 1;
    localparam int IW = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;

    localparam logic [1:0] S_HOLD      = 2'd0;
    localparam logic [1:0] S_WAIT_LOCK = 2'd1;
    localparam logic [1:0] S_RELEASE   = 2'd2;
    localparam logic [1:0] S_DONE      = 2'd3;

    logic [1:0]             state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [GW-1:0]          gap_q, gap_d;
    logic [IW-1:0]          idx_q, idx_d;
    logic [NUM_DOMAINS-1:0] rst_n_q, rst_n_d;
    logic                   done_q, done_d;
    logic                   lock_lost_q, lock_lost_d;
    logic [NUM_DOMAINS-1:0] rel_mask;

    // Releases form a thermometer code, so the next release is a shift-in of one.
    assign rel_mask = (rst_n_q << 1) | NUM_DOMAINS'(1);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        gap_d       = gap_q;
        idx_d       = idx_q;
        rst_n_d     = rst_n_q;
        done_d      = done_q;
        lock_lost_d = 1'b0;
        if (i_sw_rst) begin
            state_d = S_HOLD;
            cnt_d   = '0;
            gap_d   = '0;
            idx_d   = '0;
            rst_n_d = '0;
            done_d  = 1'b0;
        end else if (!i_lock && (state_q == S_RELEASE || state_q == S_DONE)) begin
            state_d     = S_HOLD;
            cnt_d       = '0;
            gap_d       = '0;
            idx_d       = '0;
            rst_n_d     = '0;
            done_d      = 1'b0;
            lock_lost_d = 1'b1;
        end else begin
            case (state_q)
                S_HOLD: begin
                    rst_n_d = '0;
                    done_d  = 1'b0;
                    if (cnt_q == CW'(HOLD_CYCLES - 1)) begin
                        state_d = S_WAIT_LOCK;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                S_WAIT_LOCK: begin
                    rst_n_d = '0;
                    done_d  = 1'b0;
                    if (i_lock) begin
                        rst_n_d = NUM_DOMAINS'(1);
                        idx_d   = '0;
                        gap_d   = '0;
                        if (NUM_DOMAINS == 1) begin
                            state_d = S_DONE;
                            done_d  = 1'b1;
                        end else begin
                            state_d = S_RELEASE;
                        end
                    end
                end
                S_RELEASE: begin
                    if (gap_q == GW'(STAGE_GAP - 1)) begin
                        rst_n_d = rel_mask;
                        idx_d   = idx_q + 1'b1;
                        gap_d   = '0;
                        if (&rel_mask) begin
                            state_d = S_DONE;
                            done_d  = 1'b1;
                        end
                    end else begin
                        gap_d = gap_q + 1'b1;
                    end
                end
                S_DONE: begin
                    rst_n_d = '1;
                    done_d  = 1'b1;
                end
                default: begin
                    state_d = S_HOLD;
                    rst_n_d = '0;
                    done_d  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q     <= S_HOLD;
            cnt_q       <= '0;
            gap_q       <= '0;
            idx_q       <= '0;
            rst_n_q     <= '0;
            done_q      <= 1'b0;
            lock_lost_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            gap_q       <= gap_d;
            idx_q       <= idx_d;
            rst_n_q     <= rst_n_d;
            done_q      <= done_d;
            lock_lost_q <= lock_lost_d;
        end
    end

    assign o_rst_n     = rst_n_q;
    assign o_done      = done_q;
    assign o_lock_lost = lock_lost_q;
    assign o_state     = state_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer: default instance plus a minimal 1-domain instance.
module tb_reset_sequencer;

    logic       clk = 1'b0;
    logic       rstn, sw_rst, lock;
    logic [2:0] rst_n;
    logic       done, lock_lost;
    logic [1:0] state;

    logic       rstn2, sw_rst2, lock2;
    logic [0:0] rst_n2;
    logic       done2, lock_lost2;
    logic [1:0] state2;

    int checks   = 0;
    int failures = 0;
    int e        = 0;
    int ll_cnt   = 0;

    always #5 clk = ~clk;

    reset_sequencer u_dut (
        .clk         (clk),
        .i_rstn      (rstn),
        .i_sw_rst    (sw_rst),
        .i_lock      (lock),
        .o_rst_n     (rst_n),
        .o_done      (done),
        .o_lock_lost (lock_lost),
        .o_state     (state)
    );

    reset_sequencer #(
        .NUM_DOMAINS (1),
        .HOLD_CYCLES (1),
        .STAGE_GAP   (1)
    ) u_small (
        .clk         (clk),
        .i_rstn      (rstn2),
        .i_sw_rst    (sw_rst2),
        .i_lock      (lock2),
        .o_rst_n     (rst_n2),
        .o_done      (done2),
        .o_lock_lost (lock_lost2),
        .o_state     (state2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        e++;
        if (lock_lost === 1'b1) ll_cnt++;
    endtask

    task automatic run_to(input int target);
        while (e < target) step();
    endtask

    // Pulse the reset between edges; edge numbering restarts so the next edge is edge 1.
    task automatic restart();
        rstn = 1'b0;
        #2;
        rstn = 1'b1;
        e      = 0;
        ll_cnt = 0;
    endtask

    initial begin
        rstn = 1'b0; sw_rst = 1'b0; lock = 1'b1;
        rstn2 = 1'b0; sw_rst2 = 1'b0; lock2 = 1'b1;
        #3;
        chk("rst_rst_n", 32'(rst_n), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_lock_lost", 32'(lock_lost), 32'h0);
        chk("rst_state", 32'(state), 32'h0);
        @(posedge clk); #1;
        rstn = 1'b1; e = 0; ll_cnt = 0;

        // Nominal sequence
        run_to(16);
        chk("nom_e16_rst_n", 32'(rst_n), 32'h0);
        chk("nom_e16_state", 32'(state), 32'h1);
        run_to(17);
        chk("nom_e17_rst_n", 32'(rst_n), 32'h1);
        chk("nom_e17_state", 32'(state), 32'h2);
        run_to(24);
        chk("nom_e24_rst_n", 32'(rst_n), 32'h1);
        run_to(25);
        chk("nom_e25_rst_n", 32'(rst_n), 32'h3);
        run_to(32);
        chk("nom_e32_rst_n", 32'(rst_n), 32'h3);
        chk("nom_e32_done", 32'(done), 32'h0);
        run_to(33);
        chk("nom_e33_rst_n", 32'(rst_n), 32'h7);
        chk("nom_e33_done", 32'(done), 32'h1);
        chk("nom_e33_state", 32'(state), 32'h3);
        chk("nom_no_lock_lost", 32'(ll_cnt), 32'h0);

        // Lock loss in DONE for one cycle
        lock = 1'b0;
        run_to(34);
        chk("ll_e34_rst_n", 32'(rst_n), 32'h0);
        chk("ll_e34_done", 32'(done), 32'h0);
        chk("ll_e34_pulse", 32'(lock_lost), 32'h1);
        chk("ll_e34_state", 32'(state), 32'h0);
        lock = 1'b1;
        run_to(35);
        chk("ll_e35_pulse", 32'(lock_lost), 32'h0);
        run_to(50);
        chk("ll_e50_rst_n", 32'(rst_n), 32'h0);
        run_to(51);
        chk("ll_e51_rst_n", 32'(rst_n), 32'h1);
        run_to(59);
        chk("ll_e59_rst_n", 32'(rst_n), 32'h3);
        run_to(67);
        chk("ll_e67_rst_n", 32'(rst_n), 32'h7);
        chk("ll_e67_done", 32'(done), 32'h1);
        chk("ll_single_pulse", 32'(ll_cnt), 32'h1);

        // Software reset for 3 edges mid-RELEASE
        restart();
        run_to(25);
        chk("sw_e25_rst_n", 32'(rst_n), 32'h3);
        sw_rst = 1'b1;
        run_to(26);
        chk("sw_e26_rst_n", 32'(rst_n), 32'h0);
        chk("sw_e26_done", 32'(done), 32'h0);
        chk("sw_e26_state", 32'(state), 32'h0);
        run_to(28);
        chk("sw_e28_state", 32'(state), 32'h0);
        sw_rst = 1'b0;
        run_to(44);
        chk("sw_e44_rst_n", 32'(rst_n), 32'h0);
        chk("sw_e44_state", 32'(state), 32'h1);
        run_to(45);
        chk("sw_e45_rst_n", 32'(rst_n), 32'h1);
        run_to(53);
        chk("sw_e53_rst_n", 32'(rst_n), 32'h3);
        run_to(61);
        chk("sw_e61_rst_n", 32'(rst_n), 32'h7);
        chk("sw_e61_done", 32'(done), 32'h1);
        chk("sw_no_lock_lost", 32'(ll_cnt), 32'h0);

        // Lock absent until edge 40
        lock = 1'b0;
        restart();
        run_to(15);
        chk("wl_e15_state", 32'(state), 32'h0);
        run_to(16);
        chk("wl_e16_state", 32'(state), 32'h1);
        run_to(40);
        chk("wl_e40_state", 32'(state), 32'h1);
        chk("wl_e40_rst_n", 32'(rst_n), 32'h0);
        lock = 1'b1;
        run_to(41);
        chk("wl_e41_rst_n", 32'(rst_n), 32'h1);
        chk("wl_e41_state", 32'(state), 32'h2);
        run_to(56);
        chk("wl_e56_done", 32'(done), 32'h0);
        run_to(57);
        chk("wl_e57_done", 32'(done), 32'h1);
        chk("wl_e57_rst_n", 32'(rst_n), 32'h7);
        chk("wl_no_lock_lost", 32'(ll_cnt), 32'h0);

        // Asynchronous reset mid-RELEASE, between edges
        restart();
        run_to(26);
        chk("ar_e26_rst_n", 32'(rst_n), 32'h3);
        #2;
        rstn = 1'b0;
        #1;
        chk("ar_async_rst_n", 32'(rst_n), 32'h0);
        chk("ar_async_done", 32'(done), 32'h0);
        chk("ar_async_state", 32'(state), 32'h0);
        rstn = 1'b1;

        // Minimal instance: 1 domain, hold 1, gap 1
        chk("sm_rst_rst_n", 32'(rst_n2), 32'h0);
        chk("sm_rst_done", 32'(done2), 32'h0);
        @(posedge clk); #1;
        rstn2 = 1'b1;
        e = 0;
        run_to(1);
        chk("sm_e1_rst_n", 32'(rst_n2), 32'h0);
        chk("sm_e1_state", 32'(state2), 32'h1);
        run_to(2);
        chk("sm_e2_rst_n", 32'(rst_n2), 32'h1);
        chk("sm_e2_done", 32'(done2), 32'h1);
        chk("sm_e2_state", 32'(state2), 32'h3);
        chk("sm_e2_lock_lost", 32'(lock_lost2), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
